// File: rtl/updown_display_decoder.sv
// Samples a 3-bit up/down counter, classifies each change as up/down step or jump,
// counts steps and scans value/direction/count onto a 4-digit seven-segment display.
// Optional: define UPDN_DISP_HEARTBEAT_EN to blink digit 0's decimal point per step.
module updown_display_decoder #(
  parameter int REFRESH_BITS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] q_in,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       dir_up,
  output logic       step_pulse,
  output logic       err_pulse
);

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  logic [2:0]              q_m, q_s, q_prev, d;
  logic                    armed, primed, step_det, err_det;
  logic [7:0]              ev_cnt;
  logic [REFRESH_BITS-1:0] scan_div;
  logic [1:0]              digit, digit_nx;
  logic [6:0]              glyph;
  logic                    dp_nx;

  // Synchronizer flops carry no reset so they keep tracking q_in while rst_n is low;
  // priming then captures live data on the 2nd edge after release.
  always_ff @(posedge clk) begin
    q_m <= q_in;
    q_s <= q_m;
  end

  always_comb begin
    d        = q_s - q_prev;
    step_det = primed && (d == 3'd1 || d == 3'd7);
    err_det  = primed && d != 3'd0 && !(d == 3'd1 || d == 3'd7);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed      <= 1'b0;
      primed     <= 1'b0;
      q_prev     <= 3'd0;
      dir_up     <= 1'b1;
      ev_cnt     <= 8'd0;
      step_pulse <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      armed      <= 1'b1;
      step_pulse <= step_det;
      err_pulse  <= err_det;
      if (armed && !primed) begin
        primed <= 1'b1;
        q_prev <= q_s;
      end else if (primed && d != 3'd0) begin
        q_prev <= q_s;
      end
      if (step_det) begin
        dir_up <= (d == 3'd1);
        ev_cnt <= ev_cnt + 8'd1;
      end
    end
  end

`ifdef UPDN_DISP_HEARTBEAT_EN
  logic hb;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hb <= 1'b0;
    else        hb <= hb ^ step_det;
  end
`endif

  // Outputs are registered from the next digit index so an/seg change with digit.
  always_comb begin
    digit_nx = (&scan_div) ? digit + 2'd1 : digit;
    case (digit_nx)
      2'd0:    glyph = hex7({1'b0, q_prev});
      2'd1:    glyph = dir_up ? 7'b1000001 : 7'b0100001;
      2'd2:    glyph = hex7(ev_cnt[3:0]);
      default: glyph = hex7(ev_cnt[7:4]);
    endcase
`ifdef UPDN_DISP_HEARTBEAT_EN
    dp_nx = !(digit_nx == 2'd0 && hb);
`else
    dp_nx = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_div <= '0;
      digit    <= 2'd0;
      seg      <= 7'h7F;
      an       <= 4'b1111;
      dp       <= 1'b1;
    end else begin
      scan_div <= scan_div + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
      digit    <= digit_nx;
      seg      <= glyph;
      an       <= ~(4'b0001 << digit_nx);
      dp       <= dp_nx;
    end
  end

endmodule
